// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, jump redirect with two-cycle flush, sticky stall timeout.
// Optional performance counters are built only with CTRL_PERF_CNT_EN defined.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 1023,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_stallreq_i,
  input  logic                  exe_stallreq_i,
  input  logic                  mem_stallreq_i,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic [4:0]            stall_o,
  output logic                  flush_o,
  output logic                  jump_o,
  output logic [ADDR_WIDTH-1:0] jump_addr_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  perf_stall_cycles_o,
  output logic [CNT_WIDTH-1:0]  perf_flush_cnt_o,
`endif
  output logic                  stall_timeout_o
);

  localparam int unsigned TW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {RUN, FLUSH2} state_t;

  state_t                  state, state_nxt;
  logic [4:0]              stall;
  logic                    flush;
  logic                    jump;
  logic [ADDR_WIDTH-1:0]   jump_addr;
  logic [TW-1:0]           stall_cnt, stall_cnt_nxt;
  logic                    timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 5'b00000;
    flush     = 1'b0;
    jump      = 1'b0;
    jump_addr = '0;
    case (state)
      RUN: begin
        if (mem_stallreq_i)      stall = 5'b01111;
        else if (exe_stallreq_i) stall = 5'b00111;
        else if (jump_req_i) begin
          jump      = 1'b1;
          jump_addr = jump_addr_i;
          flush     = 1'b1;
          state_nxt = FLUSH2;
        end
        else if (id_stallreq_i)  stall = 5'b00011;
      end
      FLUSH2: begin
        // Decode/execute hold wrong-path bubbles here, so only a memory wait matters.
        if (mem_stallreq_i) stall = 5'b01111;
        else begin
          flush     = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign stall_o     = rst_i ? 5'b00000 : stall;
  assign flush_o     = rst_i ? 1'b0 : flush;
  assign jump_o      = rst_i ? 1'b0 : jump;
  assign jump_addr_o = rst_i ? '0 : jump_addr;

  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (stall == 5'b00000)               stall_cnt_nxt = '0;
    else if (stall_cnt != TW'(STALL_TIMEOUT)) stall_cnt_nxt = stall_cnt + TW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      timeout_q <= timeout_q | (stall_cnt_nxt == TW'(STALL_TIMEOUT));
    end
  end

  assign stall_timeout_o = timeout_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall != 5'b00000 && perf_stall_q != '1) perf_stall_q <= perf_stall_q + CNT_WIDTH'(1);
      if (jump && perf_flush_q != '1)              perf_flush_q <= perf_flush_q + CNT_WIDTH'(1);
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flush_cnt_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs queued per driven cycle, compared per scenario.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_stallreq_i = 1'b0;
  logic        exe_stallreq_i = 1'b0;
  logic        mem_stallreq_i = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        stall_timeout_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_stall_cycles_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_stallreq_i(id_stallreq_i), .exe_stallreq_i(exe_stallreq_i),
    .mem_stallreq_i(mem_stallreq_i), .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .stall_o(stall_o), .flush_o(flush_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
`ifdef CTRL_PERF_CNT_EN
    .perf_stall_cycles_o(perf_stall_cycles_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .stall_timeout_o(stall_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  stall;
    logic        flush;
    logic        jump;
    logic [31:0] addr;
    logic        tmo;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic obs_t sample();
    return obs_t'({stall_o, flush_o, jump_o, jump_addr_o, stall_timeout_o});
  endfunction

  // Called at posedge+1: applies one cycle of requests, queues the expected outputs, samples at negedge.
  task automatic drive(input logic m, e, j, i, input logic [31:0] a,
                       input logic [4:0] es, input logic ef, ej, input logic [31:0] ea, input logic et);
    mem_stallreq_i = m; exe_stallreq_i = e; jump_req_i = j; id_stallreq_i = i; jump_addr_i = a;
    exp_q.push_back(obs_t'({es, ef, ej, ea, et}));
    @(negedge clk_i);
    obs_q.push_back(sample());
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    mem_stallreq_i = 0; exe_stallreq_i = 0; jump_req_i = 0; id_stallreq_i = 0; jump_addr_i = '0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst_i = 1'b1;
    drive(1, 1, 1, 1, 32'hdead_beef, 5'b00000, 0, 0, 32'h0, 0);
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 32'h0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL reset[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_stall_priority();
    obs_t e, o;
    do_reset();
    drive(0, 0, 0, 1, 32'h0,   5'b00011, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0,   5'b01111, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 0, 32'h0,   5'b00111, 0, 0, 32'h0, 0);
    drive(1, 1, 1, 1, 32'h44,  5'b01111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 1, 32'h0,   5'b00111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL stall_priority[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_jump();
    obs_t e, o;
    do_reset();
    drive(0, 0, 1, 0, 32'h100, 5'b00000, 1, 1, 32'h100, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 1, 0, 32'h0,   0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0,   0);
    drive(0, 0, 1, 0, 32'h200, 5'b00000, 1, 1, 32'h200, 0);
    drive(0, 0, 1, 0, 32'h300, 5'b00000, 1, 0, 32'h0,   0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0,   0);
    drive(0, 0, 1, 1, 32'h40,  5'b00000, 1, 1, 32'h40,  0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 1, 0, 32'h0,   0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL jump[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_exe_over_jump();
    obs_t e, o;
    do_reset();
    drive(0, 1, 1, 1, 32'h80, 5'b00111, 0, 0, 32'h0,  0);
    drive(0, 1, 1, 1, 32'h80, 5'b00111, 0, 0, 32'h0,  0);
    drive(0, 0, 1, 1, 32'h80, 5'b00000, 1, 1, 32'h80, 0);
    drive(0, 0, 0, 0, 32'h0,  5'b00000, 1, 0, 32'h0,  0);
    drive(0, 0, 0, 0, 32'h0,  5'b00000, 0, 0, 32'h0,  0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL exe_over_jump[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_flush_mem_stall();
    obs_t e, o;
    do_reset();
    drive(0, 0, 1, 0, 32'h100, 5'b00000, 1, 1, 32'h100, 0);
    for (int k = 0; k < 3; k++)
      drive(1, 0, 1, 1, 32'h500, 5'b01111, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 1, 0, 32'h0,   0);
    drive(0, 0, 1, 0, 32'h104, 5'b00000, 1, 1, 32'h104, 0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 1, 0, 32'h0,   0);
    drive(0, 0, 0, 0, 32'h0,   5'b00000, 0, 0, 32'h0,   0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL flush_mem_stall[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    do_reset();
    // Counter hits 4 at the end of the 4th stalled cycle; the flag is visible from the 5th.
    for (int k = 1; k <= 6; k++)
      drive(1, 0, 0, 0, 32'h0, 5'b01111, 0, 0, 32'h0, (k >= 5));
    drive(0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 32'h0, 1);
    rst_i = 1'b1; #1;
    exp_q.push_back('0);
    obs_q.push_back(sample());
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 32'h0, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL timeout[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_flush();
    obs_t e, o;
    do_reset();
    drive(0, 0, 1, 0, 32'h100, 5'b00000, 1, 1, 32'h100, 0);
    jump_req_i = 1'b0; jump_addr_i = '0;
    exp_q.push_back(obs_t'({5'b00000, 1'b1, 1'b0, 32'h0, 1'b0}));
    obs_q.push_back(sample());
    rst_i = 1'b1; #1;
    exp_q.push_back('0);
    obs_q.push_back(sample());
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 32'h0, 5'b00000, 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 0, 32'h10 * (k + 1), 5'b00000, 1, 1, 32'h10 * (k + 1), 0);
      drive(0, 0, 0, 0, 32'h0, 5'b00000, 1, 0, 32'h0, 0);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
      if (o !== e) $display("FAIL reset_in_flush[%0d] got stall=%b flush=%b jump=%b addr=%h tmo=%b, expected stall=%b flush=%b jump=%b addr=%h tmo=%b",
                            k, o.stall, o.flush, o.jump, o.addr, o.tmo, e.stall, e.flush, e.jump, e.addr, e.tmo);
      else n_pass++;
    end
`ifdef CTRL_PERF_CNT_EN
    n_total++;
    if (perf_flush_cnt_o !== 32'd3) $display("FAIL perf_flush_cnt got %0d expected 3", perf_flush_cnt_o);
    else n_pass++;
    n_total++;
    if (perf_stall_cycles_o !== 32'd0) $display("FAIL perf_stall_cycles got %0d expected 0", perf_stall_cycles_o);
    else n_pass++;
`endif
  endtask

  initial begin
    @(posedge clk_i); #1;
    test_reset();
    test_stall_priority();
    test_jump();
    test_exe_over_jump();
    test_flush_mem_stall();
    test_timeout();
    test_reset_in_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_TIMEOUT, default 1023, consecutive stalled cycles before the timeout flag sets.
REQ-002 Parameter CNT_WIDTH, default 32, width of the performance counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port id_stallreq_i, input, 1 bit: load-use hazard request from decode.
REQ-007 Port exe_stallreq_i, input, 1 bit: multi-cycle operation (M-extension) busy in execute.
REQ-008 Port mem_stallreq_i, input, 1 bit: data bus wait in memory stage.
REQ-009 Port jump_req_i, input, 1 bit: taken branch or jump resolved in execute.
REQ-010 Port jump_addr_i, input, ADDR_WIDTH bits: redirect target.
REQ-011 Port stall_o, output, 5 bits: hold per pipeline register; bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb.
REQ-012 Port flush_o, output, 1 bit: if_id and id_exe load NOP.
REQ-013 Port jump_o, output, 1 bit, and port jump_addr_o, output, ADDR_WIDTH bits: pc redirect strobe and target.
REQ-014 Port stall_timeout_o, output, 1 bit: sticky stall-timeout flag.

Function
REQ-015 stall_o, jump_o, jump_addr_o SHALL be combinational from the inputs and the current state, giving zero-cycle response to a request.
REQ-016 Request priority SHALL be mem_stallreq_i > exe_stallreq_i > jump_req_i > id_stallreq_i.
REQ-017 mem_stallreq_i SHALL give stall_o=5'b01111; exe_stallreq_i SHALL give 5'b00111; id_stallreq_i SHALL give 5'b00011; with no request, stall_o=5'b00000.
REQ-018 A stage whose stall bit is 0 while the previous stage's bit is 1 SHALL receive a bubble; this block only drives the vector.
REQ-019 In state RUN, a jump_req_i with no mem or exe request SHALL give jump_o=1, jump_addr_o=jump_addr_i, flush_o=1, stall_o=0, and transition to FLUSH2.
REQ-020 In FLUSH2, flush_o SHALL be 1 and jump_o 0, to cover the one-cycle synchronous fetch latency; the state SHALL return to RUN on the first cycle without mem_stallreq_i.
REQ-021 In FLUSH2 with mem_stallreq_i=1, stall_o SHALL be 5'b01111, flush_o 0, and the state SHALL remain FLUSH2.
REQ-022 jump_req_i in FLUSH2 SHALL be ignored.
REQ-023 When jump_o=0, jump_addr_o SHALL be 0.
REQ-024 A stall counter SHALL increment each cycle stall_o!=0 and clear when stall_o==0, saturating at STALL_TIMEOUT.
REQ-025 stall_timeout_o SHALL set on the cycle after the counter reaches STALL_TIMEOUT and SHALL stay set until reset.

Reset
REQ-026 On rst_i=1, all outputs SHALL be driven to 0 asynchronously, the state SHALL be RUN, and all counters SHALL be 0.
REQ-027 A rst_i assertion in FLUSH2 SHALL abandon the pending second flush cycle.

Configuration
REQ-028 With macro CTRL_PERF_CNT_EN defined, outputs perf_stall_cycles_o and perf_flush_cnt_o (CNT_WIDTH bits each, saturating) SHALL count cycles with stall_o!=0 and accepted jumps respectively.
REQ-029 Without CTRL_PERF_CNT_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 id_stallreq_i=1 for 1 cycle -> stall_o=5'b00011 that cycle, 5'b00000 the next, flush_o=0.
REQ-031 jump_req_i=1 with jump_addr_i=32'h0000_0100 -> jump_o=1, jump_addr_o=32'h100, flush_o=1 in cycle N; flush_o=1 and jump_o=0 in N+1; flush_o=0 in N+2.
REQ-032 jump_req_i, exe_stallreq_i and id_stallreq_i all =1 -> stall_o=5'b00111, jump_o=0; exe drops -> jump taken that cycle.
REQ-033 Jump in cycle N, mem_stallreq_i=1 in N+1..N+3 -> stall_o=5'b01111 and flush_o=0 in N+1..N+3, flush_o=1 in N+4, RUN in N+5.
REQ-034 With STALL_TIMEOUT=4 and mem_stallreq_i held 6 cycles -> stall_timeout_o rises after the 4th stalled cycle, stays 1 after the request drops, clears only on rst_i.
REQ-035 rst_i pulsed mid-FLUSH2 -> flush_o=0 immediately, state RUN, counters 0; with CTRL_PERF_CNT_EN, 3 jumps -> perf_flush_cnt_o=3.
